// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache with one-word lines.
// Byte hits are served with no stall; misses write back a dirty victim, then refill.
`timescale 1ns/1ps

module dcache_controller #(
    parameter int INDEX_BITS = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [7:0]  cpu_address,
    input  logic [7:0]  cpu_writedata,
    output logic [7:0]  cpu_readdata,
    output logic        cpu_busywait,
    output logic        mem_read,
    output logic        mem_write,
    output logic [5:0]  mem_address,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_busywait
);

    localparam int TAG_BITS = 6 - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_ALLOCATE  = 2'd2,
        S_UPDATE    = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   launched_q, launched_d;

    logic [LINES-1:0]    valid_q;
    logic [LINES-1:0]    dirty_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [31:0]         data_q [LINES];

    logic [INDEX_BITS-1:0] index_s;
    logic [TAG_BITS-1:0]   tag_s;
    logic [1:0]            offset_s;
    logic                  request_s;
    logic                  hit_s;
    logic [31:0]           line_s;
    logic                  wr_hit_s;
    logic                  fill_s;

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] off);
        logic [7:0] r;
        case (off)
            2'd0:    r = w[7:0];
            2'd1:    r = w[15:8];
            2'd2:    r = w[23:16];
            2'd3:    r = w[31:24];
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] w, input logic [1:0] off,
                                               input logic [7:0] b);
        logic [31:0] r;
        r = w;
        case (off)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            2'd3:    r[31:24] = b;
            default: r = w;
        endcase
        return r;
    endfunction

    assign index_s   = cpu_address[1+INDEX_BITS:2];
    assign tag_s     = cpu_address[7:2+INDEX_BITS];
    assign offset_s  = cpu_address[1:0];
    assign request_s = cpu_read ^ cpu_write;
    assign line_s    = data_q[index_s];
    assign hit_s     = valid_q[index_s] && (tag_q[index_s] == tag_s);

    // Next-state, memory strobes and CPU-side responses
    always_comb begin
        state_d       = state_q;
        launched_d    = launched_q;
        cpu_busywait  = 1'b0;
        cpu_readdata  = 8'h00;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = 6'h00;
        mem_writedata = 32'h0000_0000;
        wr_hit_s      = 1'b0;
        fill_s        = 1'b0;

        // Stall is suppressed while reset is held so every output reads as its reset value.
        if (reset && request_s && ((state_q != S_IDLE) || !hit_s)) begin
            cpu_busywait = 1'b1;
        end else begin
            cpu_busywait = 1'b0;
        end

        if (cpu_read && !cpu_write && hit_s) begin
            cpu_readdata = byte_sel(line_s, offset_s);
        end else begin
            cpu_readdata = 8'h00;
        end

        case (state_q)
            S_IDLE: begin
                if (request_s && !hit_s) begin
                    if (dirty_q[index_s]) begin
                        state_d = S_WRITEBACK;
                    end else begin
                        state_d = S_ALLOCATE;
                    end
                end else if (request_s && cpu_write) begin
                    wr_hit_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WRITEBACK: begin
                mem_write     = 1'b1;
                mem_address   = {tag_q[index_s], index_s};
                mem_writedata = line_s;
                // launched masks a busywait that has not yet risen on the first strobe cycle
                if (!launched_q) begin
                    launched_d = 1'b1;
                end else if (!mem_busywait) begin
                    launched_d = 1'b0;
                    state_d    = S_ALLOCATE;
                end else begin
                    launched_d = launched_q;
                end
            end
            S_ALLOCATE: begin
                mem_read    = 1'b1;
                mem_address = {tag_s, index_s};
                if (!launched_q) begin
                    launched_d = 1'b1;
                end else if (!mem_busywait) begin
                    launched_d = 1'b0;
                    state_d    = S_UPDATE;
                end else begin
                    launched_d = launched_q;
                end
            end
            S_UPDATE: begin
                fill_s  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d    = S_IDLE;
                launched_d = 1'b0;
            end
        endcase
    end

    // Controller state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            launched_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            launched_q <= launched_d;
        end
    end

    // Line storage: refill on UPDATE, byte merge on a write hit
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= {LINES{1'b0}};
            dirty_q <= {LINES{1'b0}};
            for (int i = 0; i < LINES; i++) begin
                tag_q[i]  <= {TAG_BITS{1'b0}};
                data_q[i] <= 32'h0000_0000;
            end
        end else if (fill_s) begin
            data_q[index_s]  <= mem_readdata;
            tag_q[index_s]   <= tag_s;
            valid_q[index_s] <= 1'b1;
            dirty_q[index_s] <= 1'b0;
        end else if (wr_hit_s) begin
            data_q[index_s]  <= byte_merge(line_s, offset_s, cpu_writedata);
            dirty_q[index_s] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a small fixed-latency word memory model.
`timescale 1ns/1ps

module tb_dcache_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_read = 1'b0;
    logic        cpu_write = 1'b0;
    logic [7:0]  cpu_address = 8'h00;
    logic [7:0]  cpu_writedata = 8'h00;
    logic [7:0]  cpu_readdata;
    logic        cpu_busywait;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    int vectors = 0;
    int errors  = 0;

    always #5 clock = ~clock;

    dcache_controller #(.INDEX_BITS(3)) dut (
        .clock(clock), .reset(reset),
        .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_address(cpu_address), .cpu_writedata(cpu_writedata),
        .cpu_readdata(cpu_readdata), .cpu_busywait(cpu_busywait),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
    );

    function automatic logic [31:0] preset(input logic [5:0] a);
        case (a)
            6'h00:   return 32'hDDCCBBAA;
            6'h04:   return 32'h0BADBEEF;
            6'h08:   return 32'h87654321;
            6'h11:   return 32'h44332211;
            6'h19:   return 32'hCAFEF00D;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Memory: access completes on the third posedge of a strobe; busywait rises with the strobe.
    logic [31:0] wb_mem [64];
    logic [63:0] wb_valid = 64'd0;
    logic [31:0] rdata_q = 32'h0;
    logic        ack_q = 1'b0;
    logic        ack_rd_q = 1'b0;
    int          cnt_q = 0;

    assign mem_readdata = rdata_q;
    assign mem_busywait = (mem_read || mem_write) && !(ack_q && (ack_rd_q == mem_read));

    always @(posedge clock) begin
        if (!(mem_read || mem_write)) begin
            cnt_q <= 0;
            ack_q <= 1'b0;
        end else if (ack_q && (ack_rd_q != mem_read)) begin
            cnt_q <= 0;
            ack_q <= 1'b0;
        end else if (!ack_q) begin
            if (cnt_q == 2) begin
                ack_q    <= 1'b1;
                ack_rd_q <= mem_read;
                if (mem_write) begin
                    wb_mem[mem_address]   <= mem_writedata;
                    wb_valid[mem_address] <= 1'b1;
                end else begin
                    rdata_q <= wb_valid[mem_address] ? wb_mem[mem_address] : preset(mem_address);
                end
            end else begin
                cnt_q <= cnt_q + 1;
            end
        end
    end

    // Strobe log per access; a new epoch from the stimulus clears it.
    int          epoch = 0;
    int          seen_epoch = 0;
    logic        wr_seen = 1'b0, rd_seen = 1'b0, overlap = 1'b0, order_err = 1'b0;
    logic [5:0]  wr_addr = 6'h00, rd_addr = 6'h00;
    logic [31:0] wr_data = 32'h0;

    always @(negedge clock) begin
        if (epoch != seen_epoch) begin
            seen_epoch = epoch;
            wr_seen = 1'b0; rd_seen = 1'b0; overlap = 1'b0; order_err = 1'b0;
            wr_addr = 6'h00; rd_addr = 6'h00; wr_data = 32'h0;
        end
        if (mem_write) begin
            if (rd_seen) order_err = 1'b1;
            wr_seen = 1'b1; wr_addr = mem_address; wr_data = mem_writedata;
        end
        if (mem_read) begin
            rd_seen = 1'b1; rd_addr = mem_address;
        end
        if (mem_read && mem_write) overlap = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic rd, input logic wr, input logic [7:0] addr,
                          input logic [7:0] wd, output logic [7:0] data, output int cycles);
        @(negedge clock);
        cpu_read = rd; cpu_write = wr; cpu_address = addr; cpu_writedata = wd;
        epoch++;
        cycles = 0;
        #1;
        while (cpu_busywait && cycles < 100) begin
            @(negedge clock);
            #1;
            cycles++;
        end
        check("no_timeout", 32'(cycles < 100), 32'd1);
        data = cpu_readdata;
        @(posedge clock);
        #1;
        cpu_read = 1'b0; cpu_write = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        int         cyc;

        #1;
        check("rst_busywait", 32'(cpu_busywait), 32'd0);
        check("rst_readdata", 32'(cpu_readdata), 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_mem_addr", 32'(mem_address), 32'd0);
        check("rst_mem_wdata", mem_writedata, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        access(1'b1, 1'b0, 8'h00, 8'h00, d, cyc);
        check("miss00_data", 32'(d), 32'hAA);
        check("miss00_cycles", 32'(cyc), 32'd6);
        check("miss00_rd_addr", 32'(rd_addr), 32'h00);
        check("miss00_no_wb", 32'(wr_seen), 32'd0);

        access(1'b1, 1'b0, 8'h01, 8'h00, d, cyc);
        check("hit01_data", 32'(d), 32'hBB);
        check("hit01_cycles", 32'(cyc), 32'd0);
        access(1'b1, 1'b0, 8'h02, 8'h00, d, cyc);
        check("hit02_data", 32'(d), 32'hCC);
        access(1'b1, 1'b0, 8'h03, 8'h00, d, cyc);
        check("hit03_data", 32'(d), 32'hDD);
        check("hit03_no_mem", 32'({rd_seen, wr_seen}), 32'd0);

        access(1'b0, 1'b1, 8'h02, 8'h5A, d, cyc);
        check("whit02_cycles", 32'(cyc), 32'd0);
        check("whit02_no_mem", 32'({rd_seen, wr_seen}), 32'd0);
        access(1'b1, 1'b0, 8'h02, 8'h00, d, cyc);
        check("rd02_merged", 32'(d), 32'h5A);
        access(1'b1, 1'b0, 8'h00, 8'h00, d, cyc);
        check("rd00_untouched", 32'(d), 32'hAA);

        access(1'b1, 1'b0, 8'h20, 8'h00, d, cyc);
        check("evict_wb_seen", 32'(wr_seen), 32'd1);
        check("evict_wb_addr", 32'(wr_addr), 32'h00);
        check("evict_wb_data", wr_data, 32'hDD5ABBAA);
        check("evict_rd_addr", 32'(rd_addr), 32'h08);
        check("evict_overlap", 32'(overlap), 32'd0);
        check("evict_order", 32'(order_err), 32'd0);
        check("evict_data", 32'(d), 32'h21);

        access(1'b0, 1'b1, 8'h47, 8'h9C, d, cyc);
        check("wmiss47_no_wb", 32'(wr_seen), 32'd0);
        check("wmiss47_rd_addr", 32'(rd_addr), 32'h11);
        access(1'b1, 1'b0, 8'h47, 8'h00, d, cyc);
        check("rd47_merged", 32'(d), 32'h9C);
        check("rd47_cycles", 32'(cyc), 32'd0);
        access(1'b1, 1'b0, 8'h44, 8'h00, d, cyc);
        check("rd44_kept", 32'(d), 32'h11);
        access(1'b1, 1'b0, 8'h20, 8'h00, d, cyc);
        check("rd20_other_idx", 32'(d), 32'h21);
        check("rd20_cycles", 32'(cyc), 32'd0);

        access(1'b1, 1'b0, 8'h67, 8'h00, d, cyc);
        check("evict1_wb_addr", 32'(wr_addr), 32'h11);
        check("evict1_wb_data", wr_data, 32'h9C332211);
        check("evict1_rd_addr", 32'(rd_addr), 32'h19);
        check("evict1_data", 32'(d), 32'hCA);

        @(negedge clock);
        cpu_read = 1'b1; cpu_write = 1'b1; cpu_address = 8'h84;
        epoch++;
        #1;
        check("both_no_stall", 32'(cpu_busywait), 32'd0);
        repeat (3) @(negedge clock);
        #1;
        check("both_no_mem", 32'({rd_seen, wr_seen}), 32'd0);
        check("both_readdata", 32'(cpu_readdata), 32'd0);
        cpu_read = 1'b0; cpu_write = 1'b0;

        @(negedge clock);
        cpu_read = 1'b1; cpu_address = 8'h10;
        epoch++;
        repeat (2) @(negedge clock);
        #1;
        check("alloc_mem_read", 32'(mem_read), 32'd1);
        check("alloc_mem_addr", 32'(mem_address), 32'h04);
        #2 reset = 1'b0;
        #1;
        check("arst_mem_read", 32'(mem_read), 32'd0);
        check("arst_mem_write", 32'(mem_write), 32'd0);
        check("arst_mem_addr", 32'(mem_address), 32'd0);
        check("arst_mem_wdata", mem_writedata, 32'd0);
        check("arst_busywait", 32'(cpu_busywait), 32'd0);
        check("arst_readdata", 32'(cpu_readdata), 32'd0);
        cpu_read = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        access(1'b1, 1'b0, 8'h10, 8'h00, d, cyc);
        check("remiss10_cycles", 32'(cyc), 32'd6);
        check("remiss10_rd_addr", 32'(rd_addr), 32'h04);
        check("remiss10_data", 32'(d), 32'hEF);
        access(1'b1, 1'b0, 8'h02, 8'h00, d, cyc);
        check("remiss02_cycles", 32'(cyc), 32'd6);
        check("remiss02_data", 32'(d), 32'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
